// File: rtl/dot_stream.sv
// dot_stream: streaming fixed-point dot-product engine.
// It fetches weight/activation pairs over an Avalon-MM read master and keeps
// up to MAX_OUTSTANDING reads in flight. Each pair is multiplied in Q format,
// and the products are accumulated onto a bias, with either wrap or saturating
// arithmetic. Configuration and result readback go through an Avalon-MM slave.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   slave_*                  CPU register access; waitrequest stalls while busy
//                            (status/progress reads never stall)
//   master_*                 read-only memory master; responses arrive in order
//   irq                      level done interrupt, cleared by any reg 0 access
//
// Register map (word index):
//   0 W=start / R=result     1 R=status {done, busy}
//   2 weight base            3 activation base
//   4 bias                   5 length (elements)
//   6 mode (bit0 saturate)   7 R=elements completed
module dot_stream #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned FRAC_BITS       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic        irq
);

  localparam int unsigned CNT_W  = 33;  // 2 * length reads needs one extra bit
  localparam int unsigned OUT_W  = 4;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t state, state_next;

  // Configuration registers
  logic [31:0]        wbase;
  logic [31:0]        abase;
  logic [DATA_W-1:0]  bias;
  logic [31:0]        length;
  logic               mode_sat;

  // Job state
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  weight;
  logic [DATA_W-1:0]  product;
  logic               pvalid;
  logic               done;
  logic               last_acc;
  logic [31:0]        completed;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   resp_cnt;
  logic [OUT_W-1:0]   outstanding;

  // Combinational helpers
  logic               fast_rd;
  logic               slv_rd;
  logic               slv_wr;
  logic               start;
  logic               finish;
  logic               accept;
  logic               rdv;
  logic [CNT_W-1:0]   total;
  logic [CNT_W-1:0]   iss_next;
  logic [OUT_W-1:0]   out_next;
  logic [31:0]        rd_base;
  logic [31:0]        rd_addr;
  logic               issue_more;
  logic signed [PROD_W-1:0] mult_full;
  logic [DATA_W-1:0]  product_next;
  logic [DATA_W:0]    sum_ext;
  logic [DATA_W-1:0]  acc_next;
  logic [31:0]        completed_inc;
  logic               final_acc;

  assign master_write     = 1'b0;
  assign master_writedata = 32'd0;

  // Slave decode: status/progress reads are served at once, everything else waits for IDLE
  always_comb begin
    fast_rd           = slave_read && ((slave_address == 4'd1) || (slave_address == 4'd7));
    slave_waitrequest = (state == RUN) && (slave_read || slave_write) && !fast_rd;
    slv_rd            = slave_read && !slave_waitrequest;
    slv_wr            = slave_write && !slave_waitrequest;
    slave_readdata    = 32'd0;
    if (slv_rd) begin
      case (slave_address)
        4'd0:    slave_readdata = 32'($signed(result));
        4'd1:    slave_readdata = {30'd0, done, (state == RUN)};
        4'd2:    slave_readdata = wbase;
        4'd3:    slave_readdata = abase;
        4'd4:    slave_readdata = 32'($signed(bias));
        4'd5:    slave_readdata = length;
        4'd6:    slave_readdata = {31'd0, mode_sat};
        4'd7:    slave_readdata = completed;
        default: slave_readdata = 32'd0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (slv_wr && (slave_address == 4'd0)) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_acc) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read issue: next request index, its address and the outstanding limit
  always_comb begin
    accept     = master_read && !master_waitrequest;
    rdv        = (state == RUN) && master_readdatavalid;
    total      = {length, 1'b0};
    iss_next   = issue_cnt + CNT_W'(accept);
    out_next   = outstanding + OUT_W'(accept) - OUT_W'(rdv);
    rd_base    = iss_next[0] ? abase : wbase;
    rd_addr    = rd_base + {iss_next[30:1], 2'b00};
    issue_more = (iss_next < total) && (out_next < OUT_W'(MAX_OUTSTANDING));
  end

  // Q-format multiply and wrap/saturate accumulate
  always_comb begin
    mult_full     = PROD_W'($signed(weight)) * PROD_W'($signed(master_readdata[DATA_W-1:0]));
    product_next  = DATA_W'(mult_full >>> FRAC_BITS);
    sum_ext       = (DATA_W + 1)'($signed(acc)) + (DATA_W + 1)'($signed(product));
    acc_next      = sum_ext[DATA_W-1:0];
    if (mode_sat && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
      acc_next = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    completed_inc = completed + 32'd1;
    final_acc     = pvalid && (completed_inc == length);
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wbase          <= 32'd0;
      abase          <= 32'd0;
      bias           <= '0;
      length         <= 32'd0;
      mode_sat       <= 1'b0;
      result         <= '0;
      acc            <= '0;
      weight         <= '0;
      product        <= '0;
      pvalid         <= 1'b0;
      done           <= 1'b0;
      last_acc       <= 1'b0;
      completed      <= 32'd0;
      issue_cnt      <= '0;
      resp_cnt       <= '0;
      outstanding    <= '0;
      master_read    <= 1'b0;
      master_address <= 32'd0;
      irq            <= 1'b0;
    end else begin
      pvalid <= 1'b0;

      if (slv_wr) begin
        case (slave_address)
          4'd2:    wbase    <= slave_writedata;
          4'd3:    abase    <= slave_writedata;
          4'd4:    bias     <= slave_writedata[DATA_W-1:0];
          4'd5:    length   <= slave_writedata;
          4'd6:    mode_sat <= slave_writedata[0];
          default: ;
        endcase
      end

      if ((slv_rd || slv_wr) && (slave_address == 4'd0)) begin
        irq <= 1'b0;
      end

      if (start) begin
        acc            <= bias;
        completed      <= 32'd0;
        issue_cnt      <= '0;
        resp_cnt       <= '0;
        outstanding    <= '0;
        done           <= 1'b0;
        irq            <= 1'b0;
        last_acc       <= 1'b0;
        master_read    <= (length != 32'd0);
        master_address <= wbase;
      end else if (state == RUN) begin
        issue_cnt   <= iss_next;
        outstanding <= out_next;
        master_read <= issue_more;
        if (issue_more) begin
          master_address <= rd_addr;
        end

        // Even responses are weights, odd ones complete a pair
        if (rdv) begin
          resp_cnt <= resp_cnt + CNT_W'(1);
          if (!resp_cnt[0]) begin
            weight <= master_readdata[DATA_W-1:0];
          end else begin
            product <= product_next;
            pvalid  <= 1'b1;
          end
        end

        if (pvalid) begin
          acc       <= acc_next;
          completed <= completed_inc;
        end

        // last_acc marks the final accumulate; a zero-length job uses one idle slot instead
        if (finish) begin
          result      <= acc;
          done        <= 1'b1;
          irq         <= 1'b1;
          last_acc    <= 1'b0;
          master_read <= 1'b0;
        end else if (final_acc || ((length == 32'd0) && !last_acc)) begin
          last_acc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_stream.sv
// Self-checking bench for dot_stream: CPU register tasks, a randomized in-order
// memory responder and a longint reference model of the dot product.
module tb_dot_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        irq;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  always #5 clk = ~clk;

  dot_stream #(.DATA_W(32), .FRAC_BITS(16), .MAX_OUTSTANDING(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .irq                  (irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wmem [64];
  logic [31:0] amem [64];
  logic [31:0] wbase_g = 32'h1000;
  logic [31:0] abase_g = 32'h8000;
  int          len_g   = 0;
  bit          wr_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          exp_idx = 0;
  int          rd_seen = 0;
  int          out_cnt = 0;
  int          cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t rq[$];

  function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
    logic [31:0] wo, ao;
    wo = (addr - wbase_g) >> 2;
    ao = (addr - abase_g) >> 2;
    if (wo < 32'(len_g)) return wmem[wo[5:0]];
    if (ao < 32'(len_g)) return amem[ao[5:0]];
    return 32'hDEADBEEF;
  endfunction

  // Reference: acc = bias + sum of (w*a >> 16), low 32 bits per product, wrap or clamp per step
  function automatic logic [31:0] model(input int n, input logic [31:0] b, input bit sat);
    longint a, p;
    a = longint'($signed(b));
    for (int i = 0; i < n; i++) begin
      p = (longint'($signed(wmem[i])) * longint'($signed(amem[i]))) >>> 16;
      p = longint'(int'(p));
      a = a + p;
      if (sat) begin
        if (a > MAXV) a = MAXV;
        else if (a < MINV) a = MINV;
      end else begin
        a = longint'(int'(a));
      end
    end
    return 32'(a);
  endfunction

  // Memory responder: random waitrequest, in-order responses after lat_min..lat_max cycles
  initial begin
    logic [31:0] ea;
    int          k;
    bit          acc_now, rdv;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      master_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      acc_now = (master_read === 1'b1) && !master_waitrequest;
      if (master_read === 1'b1) rd_seen++;
      rdv = 1'b0;
      master_readdatavalid = 1'b0;
      master_readdata      = 32'd0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata      = rq[0].data;
        void'(rq.pop_front());
        rdv = 1'b1;
      end
      if (acc_now) begin
        k  = (len_g > 0) ? (exp_idx % (2 * len_g)) : exp_idx;
        ea = (((k % 2) == 0) ? wbase_g : abase_g) + 32'(4 * (k / 2));
        checks++;
        if (master_address !== ea) begin
          errors++;
          $display("FAIL read_address: index %0d got %h expected %h", k, master_address, ea);
        end
        rq.push_back('{data: mem_lookup(master_address), due: cyc + $urandom_range(lat_min, lat_max)});
        exp_idx++;
      end
      out_cnt = out_cnt + int'(acc_now) - int'(rdv);
      if (acc_now) begin
        checks++;
        if (out_cnt > 4) begin
          errors++;
          $display("FAIL outstanding_limit: got %0d expected at most 4", out_cnt);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One CPU access; called and returns at posedge+1
  task automatic bus(input bit is_rd, input logic [3:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output int stall);
    slave_address   = addr;
    slave_read      = is_rd;
    slave_write     = !is_rd;
    slave_writedata = wdata;
    stall = 0;
    rdata = 32'd0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!slave_waitrequest) begin
        rdata = slave_readdata;
        break;
      end
      stall++;
    end
    checks++;
    if (stall >= 3000) begin
      errors++;
      $display("FAIL bus_timeout: reg %0d stalled %0d cycles expected fewer than 3000", addr, stall);
    end
    @(posedge clk);
    #1;
    slave_read  = 1'b0;
    slave_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d, output int st);
    bus(1'b1, a, 32'd0, d, st);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int st);
    logic [31:0] dummy;
    bus(1'b0, a, d, dummy, st);
  endtask

  task automatic cfg(input int n, input logic [31:0] wb, input logic [31:0] ab,
                     input logic [31:0] b, input bit m);
    int st;
    len_g   = n;
    wbase_g = wb;
    abase_g = ab;
    exp_idx = 0;
    wr(4'd2, wb, st);
    wr(4'd3, ab, st);
    wr(4'd4, b, st);
    wr(4'd5, 32'(n), st);
    wr(4'd6, {31'd0, m}, st);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int st, n;
    n = 0;
    do begin
      rd(4'd1, s, st);
      n++;
    end while (s[1] !== 1'b1 && n < 2000);
    checks++;
    if (s[1] !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: status %h expected done bit set", s);
    end
  endtask

  task automatic fill_random(input int n, input bit big);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = $urandom;
      wmem[i] = big ? t : {{12{t[19]}}, t[19:0]};
      t = $urandom;
      amem[i] = big ? t : {{12{t[19]}}, t[19:0]};
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int st;
    rst = 1'b1;
    slave_read = 1'b0; slave_write = 1'b0; slave_address = 4'd0; slave_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (irq !== 1'b0 || master_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: irq %b master_read %b expected 0 0", irq, master_read);
    end
    checks++;
    if (slave_waitrequest !== 1'b0 || slave_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_slave: waitrequest %b readdata %h expected 0 00000000", slave_waitrequest, slave_readdata);
    end
    rd(4'd0, v, st);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", v); end
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 00000000", v); end
    rd(4'd7, v, st);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_completed: got %h expected 00000000", v); end
  endtask

  task automatic test_ops();
    logic [31:0] v;
    logic [31:0] biases [2];
    logic [31:0] expv [2];
    int st;
    biases[0] = 32'h0; biases[1] = 32'h00010000;
    expv[0] = 32'h00020000; expv[1] = 32'h00030000;
    wmem[0] = 32'h00010000; wmem[1] = 32'h00020000; wmem[2] = 32'hFFFF8000;
    amem[0] = 32'h00030000; amem[1] = 32'h00008000; amem[2] = 32'h00040000;
    wr_rand = 1'b0; lat_min = 1; lat_max = 3;
    for (int j = 0; j < 2; j++) begin
      cfg(3, 32'h1000, 32'h8000, biases[j], 1'b0);
      wr(4'd0, 32'd0, st);
      wait_done();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL ops_irq: got %b expected 1", irq); end
      rd(4'd7, v, st);
      checks++;
      if (v !== 32'd3) begin errors++; $display("FAIL ops_completed: got %0d expected 3", v); end
      rd(4'd0, v, st);
      checks++;
      if (v !== expv[j] || v !== model(3, biases[j], 1'b0)) begin
        errors++;
        $display("FAIL ops_result: got %h expected %h", v, expv[j]);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL ops_irq_clear: got %b expected 0", irq); end
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] v;
    int st;
    rd_seen = 0;
    cfg(0, 32'h1000, 32'h8000, 32'h12345678, 1'b0);
    wr(4'd0, 32'd0, st);
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL zero_len_busy1: status %h expected 00000001", v); end
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL zero_len_busy2: status %h expected 00000001", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL zero_len_irq: got %b expected 1", irq); end
    rd(4'd0, v, st);
    checks++;
    if (v !== 32'h12345678 || st != 0) begin
      errors++;
      $display("FAIL zero_len_result: got %h stall %0d expected 12345678 stall 0", v, st);
    end
    checks++;
    if (rd_seen != 0) begin errors++; $display("FAIL zero_len_reads: got %0d reads expected 0", rd_seen); end
  endtask

  task automatic test_saturate();
    logic [31:0] v;
    logic [31:0] expv [4];
    int st;
    expv[0] = 32'h80000000; expv[1] = 32'h7FFFFFFF; expv[2] = 32'h40000000; expv[3] = 32'h80000000;
    for (int j = 0; j < 4; j++) begin
      if (j < 2) begin
        wmem[0] = 32'h40000000; wmem[1] = 32'h40000000;
        amem[0] = 32'h00010000; amem[1] = 32'h00010000;
      end else begin
        wmem[0] = 32'hC0000000; wmem[1] = 32'hC0000000;
        amem[0] = 32'h00018000; amem[1] = 32'h00018000;
      end
      cfg(2, 32'h1000, 32'h8000, 32'h0, j[0]);
      wr(4'd0, 32'd0, st);
      wait_done();
      rd(4'd0, v, st);
      checks++;
      if (v !== expv[j] || v !== model(2, 32'h0, j[0])) begin
        errors++;
        $display("FAIL saturate_%0d: got %h expected %h", j, v, expv[j]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v, b, wb;
    bit m;
    int st;
    wr_rand = 1'b1; lat_min = 1; lat_max = 8;
    for (int it = 0; it < 4; it++) begin
      fill_random(16, it == 3);
      b  = $urandom;
      m  = 1'($urandom_range(0, 1));
      wb = (it == 1) ? 32'hFFFFFFF0 : 32'h1000;
      cfg(16, wb, 32'h8000, b, m);
      wr(4'd0, 32'd0, st);
      wait_done();
      rd(4'd7, v, st);
      checks++;
      if (v !== 32'd16) begin errors++; $display("FAIL random_completed_%0d: got %0d expected 16", it, v); end
      rd(4'd0, v, st);
      checks++;
      if (v !== model(16, b, m)) begin
        errors++;
        $display("FAIL random_result_%0d: got %h expected %h", it, v, model(16, b, m));
      end
    end
    wr_rand = 1'b0;
  endtask

  task automatic test_poll_stall();
    logic [31:0] v, b;
    int st;
    lat_min = 6; lat_max = 6;
    fill_random(8, 1'b0);
    b = $urandom;
    cfg(8, 32'h1000, 32'h8000, b, 1'b0);
    wr(4'd0, 32'd0, st);
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'h1 || st != 0) begin
      errors++;
      $display("FAIL poll_status: got %h stall %0d expected 00000001 stall 0", v, st);
    end
    rd(4'd7, v, st);
    checks++;
    if (st != 0 || v > 32'd8) begin
      errors++;
      $display("FAIL poll_progress: got %0d stall %0d expected at most 8 stall 0", v, st);
    end
    rd(4'd0, v, st);
    checks++;
    if (v !== model(8, b, 1'b0) || st == 0) begin
      errors++;
      $display("FAIL poll_result_stall: got %h stall %0d expected %h with stall", v, st, model(8, b, 1'b0));
    end
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL poll_status_done: got %h expected 00000002", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL poll_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, b;
    int st;
    lat_min = 1; lat_max = 4;
    fill_random(4, 1'b0);
    b = $urandom;
    cfg(4, 32'h1000, 32'h8000, b, 1'b1);
    wr(4'd0, 32'd0, st);
    wr(4'd0, 32'd0, st);
    checks++;
    if (st == 0) begin errors++; $display("FAIL b2b_held_start: stall %0d expected nonzero", st); end
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL b2b_second_busy: status %h expected 00000001", v); end
    wait_done();
    rd(4'd0, v, st);
    checks++;
    if (v !== model(4, b, 1'b1)) begin
      errors++;
      $display("FAIL b2b_result: got %h expected %h", v, model(4, b, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, b;
    int st, n;
    wr_rand = 1'b0; lat_min = 8; lat_max = 8;
    fill_random(8, 1'b0);
    cfg(8, 32'h1000, 32'h8000, 32'h0BADF00D, 1'b0);
    wr(4'd0, 32'd0, st);
    n = 0;
    while (exp_idx < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_idx < 5) begin errors++; $display("FAIL rst_mid_accepts: got %0d expected 5", exp_idx); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (master_read !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: master_read %b irq %b expected 0 0", master_read, irq);
    end
    rst = 1'b0;
    n = 0;
    while (rq.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    rd(4'd0, v, st);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_result: got %h expected 00000000", v); end
    rd(4'd1, v, st);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000000", v); end
    rd(4'd7, v, st);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_progress: completed %0d irq %b expected 0 0", v, irq);
    end
    wr_rand = 1'b1; lat_min = 1; lat_max = 8;
    fill_random(6, 1'b0);
    b = $urandom;
    cfg(6, 32'h2000, 32'h9000, b, 1'b0);
    wr(4'd0, 32'd0, st);
    wait_done();
    rd(4'd0, v, st);
    checks++;
    if (v !== model(6, b, 1'b0)) begin
      errors++;
      $display("FAIL rst_mid_new_job: got %h expected %h", v, model(6, b, 1'b0));
    end
    wr_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_zero_len();
    test_saturate();
    test_random();
    test_poll_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
